regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined core.
//  - NUM_RD combinational read ports and NUM_WR write ports.
//  - Optional write-to-read bypass and a hardwired-zero register.
//  - Per-register busy scoreboard for pending writebacks.
//  - Sequential sweep-clear engine for context flush.
//  - Sits between decode (reads, busy check, alloc) and writeback (writes).

---
 rtl/regfile_mp.sv | 153 +++++++++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, busy scoreboard and
// a sequential sweep-clear engine for context flush.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rs_data,
    output logic [NUM_RD-1:0]        o_rs_busy,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic                     i_clear,
    output logic                     o_ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              idle;
    logic [NUM_WR-1:0] wr_ok;
    logic              alloc_ok;

    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] bdata;

    assign idle    = (state == ST_IDLE);
    assign o_ready = idle;

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_clear) state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Qualified write and alloc requests; reg 0 is immutable with ZERO_REG
    always_comb begin
        wr_ok = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wr_ok[p] = idle && i_wr_en[p] &&
                       !(ZERO_REG && (i_wr_addr[p*ADDR_W +: ADDR_W] == '0));
        end
        alloc_ok = idle && i_alloc_en && !(ZERO_REG && (i_alloc_addr == '0));
    end

    // Sweep counter, held at zero while idle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (idle) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Storage: later write ports override earlier ones on address collision
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (idle) begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) begin
                    regs[i_wr_addr[p*ADDR_W +: ADDR_W]] <= i_wr_data[p*DATA_W +: DATA_W];
                end
            end
        end else begin
            regs[cnt] <= '0;
        end
    end

    // Busy scoreboard: writeback clears, alloc sets and wins, clear start flushes
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy <= '0;
        end else if (idle) begin
            if (i_clear) begin
                busy <= '0;
            end else begin
                for (int unsigned p = 0; p < NUM_WR; p++) begin
                    if (wr_ok[p]) begin
                        busy[i_wr_addr[p*ADDR_W +: ADDR_W]] <= 1'b0;
                    end
                end
                if (alloc_ok) begin
                    busy[i_alloc_addr] <= 1'b1;
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        o_rs_data = '0;
        o_rs_busy = '0;
        ra        = '0;
        hit       = 1'b0;
        bdata     = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra    = i_rs_addr[k*ADDR_W +: ADDR_W];
            hit   = 1'b0;
            bdata = '0;
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (BYPASS && wr_ok[p] && (i_wr_addr[p*ADDR_W +: ADDR_W] == ra)) begin
                    hit   = 1'b1;
                    bdata = i_wr_data[p*DATA_W +: DATA_W];
                end
            end
            if (ZERO_REG && (ra == '0)) begin
                o_rs_data[k*DATA_W +: DATA_W] = '0;
                o_rs_busy[k]                  = 1'b0;
            end else if (hit) begin
                o_rs_data[k*DATA_W +: DATA_W] = bdata;
                o_rs_busy[k]                  = 1'b0;
            end else begin
                o_rs_data[k*DATA_W +: DATA_W] = regs[ra];
                o_rs_busy[k]                  = idle && busy[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus; expectations are queued per cycle and checked on negedge.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data, rs_data_nb;
    logic [1:0]  rs_busy, rs_busy_nb;
    logic        rdy, rdy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        clr;

    always #5 clk = ~clk;

    regfile_mp dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rs_addr(rs_addr), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_clear(clr), .o_ready(rdy)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rs_addr(rs_addr), .o_rs_data(rs_data_nb), .o_rs_busy(rs_busy_nb),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_clear(clr), .o_ready(rdy_nb)
    );

    typedef struct packed {
        int          cyc;
        bit          inst;
        bit [1:0]    port;
        logic [31:0] data;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
        wr_en    = '0;
        alloc_en = 1'b0;
        clr      = 1'b0;
        rs_addr  = '0;
    endtask

    task automatic rd(input int p, input int a);
        rs_addr[p*5 +: 5] = 5'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*5 +: 5]   = 5'(a);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic ex(input bit inst, input int p, input logic [31:0] d,
                      input logic b, input logic r, input string n);
        exp_t e;
        e.cyc   = cyc;
        e.inst  = inst;
        e.port  = 2'(p);
        e.data  = d;
        e.busy  = b;
        e.ready = r;
        q.push_back(e);
        qn.push_back(n);
    endtask

    task automatic ex2(input int p, input logic [31:0] d_bp, input logic [31:0] d_nb,
                       input logic b_bp, input logic b_nb, input logic r, input string n);
        ex(1'b0, p, d_bp, b_bp, r, n);
        ex(1'b1, p, d_nb, b_nb, r, {n, "_nb"});
    endtask

    // Monitor: pop every expectation due this cycle and compare
    always @(negedge clk) begin
        exp_t        e;
        string       n;
        logic [31:0] ad;
        logic        ab, ar;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n = qn.pop_front();
            if (e.inst) begin
                ad = rs_data_nb[int'(e.port)*32 +: 32];
                ab = rs_busy_nb[e.port];
                ar = rdy_nb;
            end else begin
                ad = rs_data[int'(e.port)*32 +: 32];
                ab = rs_busy[e.port];
                ar = rdy;
            end
            total++;
            if (e.cyc != cyc || ad !== e.data || ab !== e.busy || ar !== e.ready) begin
                bad++;
                $display("FAIL %s cyc=%0d/%0d got data=%h busy=%b ready=%b need data=%h busy=%b ready=%b",
                         n, cyc, e.cyc, ad, ab, ar, e.data, e.busy, e.ready);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        rs_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clr        = 1'b0;

        // Reset state
        step(); rd(0, 5); rd(1, 17);
        ex2(0, 0, 0, 0, 0, 1, "rst_p0");
        ex2(1, 0, 0, 0, 0, 1, "rst_p1");
        step(); rst_n = 1'b1;

        // 1: every address on every port reads zero
        for (int a = 0; a < 32; a++) begin
            step(); rd(0, a); rd(1, 31 - a);
            ex2(0, 0, 0, 0, 0, 1, "init_p0");
            ex2(1, 0, 0, 0, 0, 1, "init_p1");
        end

        // 2: port collision, higher port wins; zero register
        step(); wr(0, 5, 32'h1111); wr(1, 5, 32'h2222); rd(0, 5);
        ex2(0, 32'h2222, 0, 0, 0, 1, "coll_same");
        step(); rd(0, 5); rd(1, 5);
        ex2(0, 32'h2222, 32'h2222, 0, 0, 1, "coll_next_p0");
        ex2(1, 32'h2222, 32'h2222, 0, 0, 1, "coll_next_p1");
        step(); wr(0, 0, 32'hFFFF); rd(1, 0);
        ex2(1, 0, 0, 0, 0, 1, "zero_same");
        step(); rd(0, 0);
        ex2(0, 0, 0, 0, 0, 1, "zero_next");

        // 3: bypass vs. no bypass
        step(); wr(0, 7, 32'hABCD); rd(0, 7);
        ex2(0, 32'hABCD, 0, 0, 0, 1, "byp_same");
        step(); rd(0, 7);
        ex2(0, 32'hABCD, 32'hABCD, 0, 0, 1, "byp_next");

        // 4: busy scoreboard
        step(); alloc_en = 1'b1; alloc_addr = 5'd3; rd(0, 3);
        ex2(0, 0, 0, 0, 0, 1, "alloc_same");
        step(); rd(0, 3);
        ex2(0, 0, 0, 1, 1, 1, "alloc_next");
        step(); alloc_en = 1'b1; alloc_addr = 5'd3; wr(1, 3, 32'h33); rd(1, 3);
        ex2(1, 32'h33, 0, 0, 1, 1, "alloc_wr_same");
        step(); rd(1, 3);
        ex2(1, 32'h33, 32'h33, 1, 1, 1, "alloc_wr_next");
        step(); wr(0, 3, 32'h44); rd(0, 4);
        ex2(0, 0, 0, 0, 0, 1, "wr_r4_idle");
        step(); rd(0, 3);
        ex2(0, 32'h44, 32'h44, 0, 0, 1, "wr_clr_busy");

        // 5: fill, then sweep-clear
        for (int i = 1; i < 32; i++) begin
            step(); wr(i % 2, i, 32'(i));
        end
        step(); alloc_en = 1'b1; alloc_addr = 5'd12;
        step(); clr = 1'b1; wr(0, 20, 32'h99); alloc_en = 1'b1; alloc_addr = 5'd12;
        rd(0, 12); rd(1, 20);
        ex2(0, 32'd12, 32'd12, 1, 1, 1, "clr_req_p0");
        ex2(1, 32'h99, 32'd20, 0, 0, 1, "clr_req_p1");
        for (int c = 0; c < 32; c++) begin
            step(); rd(0, c); rd(1, 9);
            if (c == 5) begin
                wr(0, 9, 32'h55); wr(1, 9, 32'h56);
                alloc_en = 1'b1; alloc_addr = 5'd9; clr = 1'b1;
            end
            ex2(0, (c == 0) ? 32'd0 : (c == 20) ? 32'h99 : 32'(c),
                   (c == 0) ? 32'd0 : (c == 20) ? 32'h99 : 32'(c), 0, 0, 0, "sweep_p0");
            ex2(1, (c <= 9) ? 32'd9 : 32'd0, (c <= 9) ? 32'd9 : 32'd0, 0, 0, 0, "sweep_p1");
        end
        for (int a = 0; a < 32; a++) begin
            step(); rd(0, a); rd(1, 31 - a);
            ex2(0, 0, 0, 0, 0, 1, "post_sweep_p0");
            ex2(1, 0, 0, 0, 0, 1, "post_sweep_p1");
        end

        // 6: reset in the middle of a sweep
        step(); wr(0, 30, 32'h30); wr(1, 2, 32'h22);
        step(); clr = 1'b1; rd(0, 30);
        ex2(0, 32'h30, 32'h30, 0, 0, 1, "rst6_req");
        for (int c = 0; c < 10; c++) begin
            step(); rd(0, 30);
            ex2(0, 32'h30, 32'h30, 0, 0, 0, "rst6_sweep");
        end
        step(); rst_n = 1'b0; rd(0, 30); rd(1, 2);
        ex2(0, 0, 0, 0, 0, 1, "rst6_async_p0");
        ex2(1, 0, 0, 0, 0, 1, "rst6_async_p1");
        step(); rst_n = 1'b1; rd(0, 30);
        ex2(0, 0, 0, 0, 0, 1, "rst6_release");
        step(); wr(0, 30, 32'h77); rd(0, 30);
        ex2(0, 32'h77, 0, 0, 0, 1, "rst6_wr_same");
        step(); rd(0, 30);
        ex2(0, 32'h77, 32'h77, 0, 0, 1, "rst6_wr_next");

        step();
        step();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL unchecked_expectations left=%0d need=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
